mole_rand_sel: RTL and testbench

- Parametrised pseudo-random hole selector for the whack-a-mole game. Generalises the free-running wrap counter into a request/valid block.
- Internals: a Galois LFSR with loadable seed, unbiased range mapping by rejection sampling, an optional no-immediate-repeat mode, and a bounded-retry fallback counter.
- Sits between the game controller, which issues `req`, and the mole display logic, which consumes `rand_out`.

---
 rtl/mole_rand_sel.sv | 203 ++++++++++++++++++++
 tb/tb_mole_rand_sel.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_rand_sel.sv
// Pseudo-random hole selector: Galois LFSR, rejection-sampled range mapping,
// optional no-immediate-repeat, and a bounded-retry fallback counter.
module mole_rand_sel #(
  parameter int                WIDTH     = 5,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                RANGE_MIN = 1,
  parameter int                RANGE_MAX = 30,
  parameter int                NO_REPEAT = 1,
  parameter int                MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  output logic              busy,
  output logic              rand_valid,
  output logic [WIDTH-1:0]  rand_out,
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam int                TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [WIDTH-1:0]  MIN_W     = WIDTH'(RANGE_MIN);
  localparam logic [WIDTH-1:0]  MAX_W     = WIDTH'(RANGE_MAX);
  localparam logic [WIDTH-1:0]  SPAN_W    = MAX_W - MIN_W;
  localparam logic [WIDTH-1:0]  ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TRY_W-1:0]  TRY_LIM   = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0]  TRY_ONE   = {{(TRY_W-1){1'b0}}, 1'b1};
  localparam logic [TRY_W-1:0]  TRY_ZERO  = {TRY_W{1'b0}};
  localparam logic [LFSR_W-1:0] LFSR_ZERO = {LFSR_W{1'b0}};
  localparam logic              NR        = (NO_REPEAT != 0);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    logic [LFSR_W-1:0] sh;
    sh = {1'b0, q[LFSR_W-1:1]};
    if (q[0]) begin
      lfsr_step = sh ^ TAPS;
    end else begin
      lfsr_step = sh;
    end
  endfunction

  function automatic logic [WIDTH-1:0] fb_inc(input logic [WIDTH-1:0] v);
    if (v == MAX_W) begin
      fb_inc = MIN_W;
    end else begin
      fb_inc = v + ONE_W;
    end
  endfunction

  state_t            state_r, state_s;
  logic [LFSR_W-1:0] lfsr_r, lfsr_s;
  logic [TRY_W-1:0]  try_r, try_s;
  logic [WIDTH-1:0]  fb_r, fb_s;
  logic [WIDTH-1:0]  rand_out_r, rand_out_s;
  logic              rand_valid_r, rand_valid_s;
  logic              last_valid_r, last_valid_s;
  logic              busy_r, busy_s;

  logic [WIDTH-1:0]  cand_s;
  logic [WIDTH-1:0]  cand_off_s;
  logic              in_range_s;
  logic              repeat_s;
  logic              accept_s;
  logic              tries_done_s;
  logic              search_act_s;
  logic              emit_fb_s;
  logic              emit_rand_s;
  logic              emit_s;
  logic              fb_hit_s;
  logic [WIDTH-1:0]  fb_val_s;

  // Offset-from-minimum compare: one unsigned test covers both range bounds.
  assign cand_s       = lfsr_r[WIDTH-1:0];
  assign cand_off_s   = cand_s - MIN_W;
  assign in_range_s   = (cand_off_s <= SPAN_W);
  assign repeat_s     = NR && last_valid_r && (cand_s == rand_out_r);
  assign accept_s     = in_range_s && !repeat_s;
  assign tries_done_s = (try_r >= TRY_LIM);
  assign search_act_s = (state_r == ST_SEARCH) && en && !seed_load;
  assign emit_fb_s    = search_act_s && tries_done_s;
  assign emit_rand_s  = search_act_s && !tries_done_s && accept_s;
  assign emit_s       = emit_fb_s || emit_rand_s;
  assign fb_hit_s     = NR && (fb_r == rand_out_r);
  assign fb_val_s     = fb_hit_s ? fb_inc(fb_r) : fb_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a seed load always returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (seed_load) begin
          state_s = ST_IDLE;
        end else if (req) begin
          state_s = ST_SEARCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (seed_load || emit_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SEARCH;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values; the LFSR runs in every state.
  always_comb begin
    lfsr_s       = lfsr_r;
    try_s        = try_r;
    fb_s         = fb_r;
    rand_out_s   = rand_out_r;
    rand_valid_s = 1'b0;
    last_valid_s = last_valid_r;
    busy_s       = 1'b0;

    if (seed_load) begin
      if (seed_in == LFSR_ZERO) begin
        lfsr_s = SEED;
      end else begin
        lfsr_s = seed_in;
      end
    end else if (en) begin
      lfsr_s = lfsr_step(lfsr_r);
    end else begin
      lfsr_s = lfsr_r;
    end

    if (seed_load) begin
      try_s = TRY_ZERO;
    end else if ((state_r == ST_IDLE) && req) begin
      try_s = TRY_ZERO;
    end else if (search_act_s && !tries_done_s && !accept_s) begin
      try_s = try_r + TRY_ONE;
    end else begin
      try_s = try_r;
    end

    // The fallback counter moves past whatever value actually went out.
    if (emit_fb_s) begin
      rand_out_s = fb_val_s;
      fb_s       = fb_inc(fb_val_s);
    end else if (emit_rand_s) begin
      rand_out_s = cand_s;
      fb_s       = fb_inc(fb_r);
    end else begin
      rand_out_s = rand_out_r;
      fb_s       = fb_r;
    end

    rand_valid_s = emit_s;
    last_valid_s = emit_s || last_valid_r;
    busy_s       = (state_s == ST_SEARCH);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r       <= SEED;
      try_r        <= TRY_ZERO;
      fb_r         <= MIN_W;
      rand_out_r   <= {WIDTH{1'b0}};
      rand_valid_r <= 1'b0;
      last_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      lfsr_r       <= lfsr_s;
      try_r        <= try_s;
      fb_r         <= fb_s;
      rand_out_r   <= rand_out_s;
      rand_valid_r <= rand_valid_s;
      last_valid_r <= last_valid_s;
      busy_r       <= busy_s;
    end
  end

  assign busy       = busy_r;
  assign rand_valid = rand_valid_r;
  assign rand_out   = rand_out_r;
  assign lfsr_q     = lfsr_r;

endmodule

// File: tb/tb_mole_rand_sel.sv
// Directed bench for mole_rand_sel: three parameterisations sharing one clock.
module tb_mole_rand_sel;

  logic        clk;
  logic        rst;
  logic        en;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req_d, req_f, req_b;

  logic        busy_d, busy_f, busy_b;
  logic        valid_d, valid_f, valid_b;
  logic [4:0]  out_d, out_f, out_b;
  logic [15:0] lfsr_d, lfsr_f, lfsr_b;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [15:0] seed;
    logic [4:0]  exp_out;
    logic [15:0] exp_lfsr;
  } vec_t;

  vec_t vecs[6];

  mole_rand_sel dut_d (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .req(req_d), .busy(busy_d), .rand_valid(valid_d), .rand_out(out_d), .lfsr_q(lfsr_d)
  );

  mole_rand_sel #(.RANGE_MIN(0), .RANGE_MAX(31), .NO_REPEAT(0)) dut_f (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .req(req_f), .busy(busy_f), .rand_valid(valid_f), .rand_out(out_f), .lfsr_q(lfsr_f)
  );

  mole_rand_sel #(.RANGE_MIN(30), .RANGE_MAX(30), .NO_REPEAT(0), .MAX_TRIES(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .req(req_b), .busy(busy_b), .rand_valid(valid_b), .rand_out(out_b), .lfsr_q(lfsr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int v, input int lo, input int hi);
    n_chk++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic chk_ne(input string name, input int v, input int prev);
    n_chk++;
    if (v == prev) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected anything but %0d", name, v, prev);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int lat;
    bit got;

    n_chk  = 0;
    n_fail = 0;
    // seed -> first output and LFSR after the accepting edge, full 0..31 range
    vecs[0] = '{16'h0001, 5'd0,  16'h5A00};
    vecs[1] = '{16'h0000, 5'd16, 16'h7138};
    vecs[2] = '{16'hFFFF, 5'd31, 16'hD1FF};
    vecs[3] = '{16'h0002, 5'd1,  16'hB400};
    vecs[4] = '{16'h1234, 5'd26, 16'h048D};
    vecs[5] = '{16'h8000, 5'd0,  16'h2000};

    rst = 1'b1; en = 1'b1; seed_load = 1'b0; seed_in = 16'h0000;
    req_d = 1'b0; req_f = 1'b0; req_b = 1'b0;
    tick();
    tick();
    chk("rst_lfsr",  32'(lfsr_f),  32'hACE1);
    chk("rst_out",   32'(out_f),   32'h0);
    chk("rst_valid", 32'(valid_f), 32'h0);
    chk("rst_busy",  32'(busy_f),  32'h0);
    chk("rst_lfsr_b", 32'(lfsr_b), 32'hACE1);

    // Request in cycle 0 after reset, on the full-range and fallback instances.
    rst = 1'b0; req_f = 1'b1; req_b = 1'b1;
    tick();
    chk("e1_lfsr",  32'(lfsr_f),  32'hE270);
    chk("e1_busy",  32'(busy_f),  32'h1);
    chk("e1_valid", 32'(valid_f), 32'h0);
    req_f = 1'b0; req_b = 1'b0;
    tick();
    chk("e2_valid", 32'(valid_f), 32'h1);
    chk("e2_out",   32'(out_f),   32'd16);
    chk("e2_lfsr",  32'(lfsr_f),  32'h7138);
    chk("e2_busy",  32'(busy_f),  32'h0);
    chk("e2_fb_busy", 32'(busy_b), 32'h1);
    for (int e = 3; e <= 5; e++) begin
      tick();
      chk("fb_early_valid", 32'(valid_b), 32'h0);
    end
    chk("pulse_width", 32'(valid_f), 32'h0);
    chk("hold_out",    32'(out_f),   32'd16);
    tick();
    chk("fb_valid", 32'(valid_b), 32'h1);
    chk("fb_out",   32'(out_b),   32'd30);
    chk("fb_busy",  32'(busy_b),  32'h0);

    for (int i = 0; i < 6; i++) begin
      seed_load = 1'b1; seed_in = vecs[i].seed;
      tick();
      seed_load = 1'b0; req_f = 1'b1;
      tick();
      req_f = 1'b0;
      tick();
      chk("vec_valid", 32'(valid_f), 32'h1);
      chk("vec_out",   32'(out_f),   32'(vecs[i].exp_out));
      chk("vec_lfsr",  32'(lfsr_f),  32'(vecs[i].exp_lfsr));
    end

    // Defaults: 8 rejects from seed 8000, with a 5-cycle en freeze mid-search.
    rst = 1'b1;
    tick();
    rst = 1'b0; seed_load = 1'b1; seed_in = 16'h8000;
    tick();
    seed_load = 1'b0; req_d = 1'b1;
    tick();
    req_d = 1'b0;
    chk("frz_e1_lfsr", 32'(lfsr_d), 32'h4000);
    chk("frz_e1_busy", 32'(busy_d), 32'h1);
    tick();
    tick();
    chk("frz_e3_lfsr", 32'(lfsr_d), 32'h1000);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("frz_lfsr",  32'(lfsr_d),  32'h1000);
      chk("frz_valid", 32'(valid_d), 32'h0);
      chk("frz_busy",  32'(busy_d),  32'h1);
    end
    en = 1'b1;
    for (int k = 4; k <= 9; k++) begin
      tick();
      chk("resume_valid", 32'(valid_d), 32'h0);
    end
    chk("resume_lfsr", 32'(lfsr_d), 32'h0040);
    tick();
    chk("dfb_valid", 32'(valid_d), 32'h1);
    chk("dfb_out",   32'(out_d),   32'd1);
    chk("dfb_lfsr",  32'(lfsr_d),  32'h0020);
    chk("dfb_busy",  32'(busy_d),  32'h0);

    // Seed load with zero aborts a running search.
    seed_load = 1'b1; seed_in = 16'h8000;
    tick();
    seed_load = 1'b0; req_d = 1'b1;
    tick();
    req_d = 1'b0;
    tick();
    chk("abort_pre_busy", 32'(busy_d), 32'h1);
    seed_load = 1'b1; seed_in = 16'h0000;
    tick();
    seed_load = 1'b0;
    chk("abort_lfsr",  32'(lfsr_d),  32'hACE1);
    chk("abort_busy",  32'(busy_d),  32'h0);
    chk("abort_valid", 32'(valid_d), 32'h0);
    tick();
    chk("abort_idle_lfsr",  32'(lfsr_d),  32'hE270);
    chk("abort_idle_busy",  32'(busy_d),  32'h0);
    chk("abort_idle_valid", 32'(valid_d), 32'h0);
    req_d = 1'b1;
    tick();
    req_d = 1'b0;
    chk("post_abort_busy", 32'(busy_d), 32'h1);
    chk("post_abort_lfsr", 32'(lfsr_d), 32'h7138);
    tick();
    chk("post_abort_valid", 32'(valid_d), 32'h1);
    chk("post_abort_out",   32'(out_d),   32'd24);
    chk("post_abort_lfsr2", 32'(lfsr_d),  32'h389C);

    // Back-to-back requests: each issued in the previous rand_valid cycle.
    prev = int'(out_d);
    for (int i = 0; i < 1000; i++) begin
      req_d = 1'b1;
      tick();
      req_d = 1'b0;
      chk("rnd_pulse", 32'(valid_d), 32'h0);
      chk("rnd_b2b_busy", 32'(busy_d), 32'h1);
      lat = 1;
      got = 1'b0;
      while (lat < 12 && !got) begin
        tick();
        lat++;
        if (valid_d) got = 1'b1;
      end
      chk("rnd_timeout", 32'(got), 32'h1);
      if (!got) break;
      chk_rng("rnd_range", int'(out_d), 1, 30);
      chk_ne("rnd_repeat", int'(out_d), prev);
      chk_rng("rnd_latency", lat, 2, 10);
      prev = int'(out_d);
    end

    // Reset mid-search, then reset together with a seed load.
    seed_load = 1'b1; seed_in = 16'h8000;
    tick();
    seed_load = 1'b0; req_d = 1'b1;
    tick();
    req_d = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_lfsr",  32'(lfsr_d),  32'hACE1);
    chk("mrst_out",   32'(out_d),   32'h0);
    chk("mrst_valid", 32'(valid_d), 32'h0);
    chk("mrst_busy",  32'(busy_d),  32'h0);
    seed_load = 1'b1; seed_in = 16'h1234;
    tick();
    chk("rst_wins_lfsr", 32'(lfsr_d), 32'hACE1);
    chk("rst_wins_busy", 32'(busy_d), 32'h0);
    rst = 1'b0; seed_in = 16'h8000;
    tick();
    seed_load = 1'b0; req_d = 1'b1;
    tick();
    req_d = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      tick();
    end
    chk("rfb_pre_valid", 32'(valid_d), 32'h0);
    tick();
    chk("rfb_valid", 32'(valid_d), 32'h1);
    chk("rfb_out",   32'(out_d),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
